// File: rtl/cell_pos_reader_if.sv
// Particle beat stream from the cell position reader into the force pipeline.
// The master drives a beat; the slave accepts it with out_ready.
interface cell_pos_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/cell_pos_reader.sv
// Reads the particle count of one cell RAM, then streams every particle
// position as beats, using a credit-tracked FIFO to absorb RAM latency.
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    cell_pos_reader_if.master     out
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        FIN
    } state_t;

    state_t state;

    logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] f_idx  [FIFO_DEPTH];
    logic                  f_last [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic                  v1;
    logic                  v2;
    logic [ADDR_WIDTH-1:0] i1;
    logic [ADDR_WIDTH-1:0] i2;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  wait_ph;

    logic [CW:0]           used;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] cnt_clamped;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Credit: reads still in the RAM pipe plus queued beats must leave room.
    assign used  = {1'b0, fifo_count} + (CW + 1)'(v1) + (CW + 1)'(v2);
    assign issue = (state == STREAM) && (used < DEPTH_C);
    assign push  = v2;
    assign pop   = (fifo_count != '0) && out.out_ready;

    assign cnt_clamped = (mem_q[ADDR_WIDTH-1:0] > CNT_MAX) ?
                         CNT_MAX : mem_q[ADDR_WIDTH-1:0];

    assign mem_rden    = issue || (state == REQ_CNT);
    assign mem_address = issue ? next_addr : '0;
    assign mem_wren    = 1'b0;

    assign out.out_valid = (fifo_count != '0);
    assign out.out_data  = f_data[rd_ptr];
    assign out.out_index = f_idx[rd_ptr];
    assign out.out_last  = f_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            particle_count <= '0;
            next_addr      <= '0;
            wait_ph        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= REQ_CNT;
                        busy  <= 1'b1;
                    end
                end
                REQ_CNT: begin
                    state   <= WAIT_CNT;
                    wait_ph <= 1'b0;
                end
                WAIT_CNT: begin
                    if (!wait_ph) begin
                        wait_ph <= 1'b1;
                    end else begin
                        particle_count <= cnt_clamped;
                        next_addr      <= ADDR_WIDTH'(1);
                        if (cnt_clamped == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (issue) begin
                        next_addr <= next_addr + 1'b1;
                        if (next_addr == particle_count)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last beat is the final entry, so its handshake ends the cell.
                    if (pop && out.out_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            i1         <= '0;
            i2         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                f_data[k] <= '0;
                f_idx[k]  <= '0;
                f_last[k] <= 1'b0;
            end
        end else begin
            v1 <= issue;
            i1 <= next_addr;
            v2 <= v1;
            i2 <= i1;
            if (push) begin
                f_data[wr_ptr] <= mem_q;
                f_idx[wr_ptr]  <= i2;
                f_last[wr_ptr] <= (i2 == particle_count);
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader: RAM model, beat scoreboard,
// timing, credit, stall, clamp, reset and re-start checks.
module tb_cell_pos_reader;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_count;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    always #5 clk = ~clk;

    cell_pos_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) out_if ();

    cell_pos_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .PARTICLE_NUM(PN),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .particle_count(particle_count),
        .mem_address(mem_address),
        .mem_rden(mem_rden),
        .mem_wren(mem_wren),
        .mem_q(mem_q),
        .out(out_if)
    );

    logic [DW-1:0] ram [256];
    logic [DW-1:0] r1;

    always @(posedge clk) begin
        r1    <= mem_rden ? ram[mem_address] : 'x;
        mem_q <= r1;
    end

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] i;
        logic          l;
    } beat_t;

    beat_t  exp_q [$];
    int     rd_log [$];
    int     hs_log [$];
    int     tests_run = 0;
    int     fails = 0;
    int     cyc = 0;
    int     t0 = 0;
    int     done_cnt = 0;
    int     done_rel = -1;
    int     outstanding = 0;
    bit     valid_seen = 0;
    bit     wren_seen = 0;
    bit     prev_stall = 0;
    beat_t  prev_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (mem_wren) wren_seen = 1;
        if (out_if.out_valid) valid_seen = 1;
        if (prev_stall) begin
            check("stall_valid", DW'(out_if.out_valid), DW'(1));
            check("stall_data", out_if.out_data, prev_b.d);
            check("stall_index", DW'(out_if.out_index), DW'(prev_b.i));
            check("stall_last", DW'(out_if.out_last), DW'(prev_b.l));
        end
        if (mem_rden) begin
            rd_log.push_back(int'(mem_address));
            if (mem_address != '0) begin
                outstanding++;
                check("credit", DW'(outstanding <= FD), DW'(1));
            end
        end
        if (out_if.out_valid && out_if.out_ready) begin
            hs_log.push_back(cyc - t0);
            outstanding--;
            if (exp_q.size() == 0) begin
                check("extra_beat", DW'(out_if.out_index), DW'(0));
            end else begin
                b = exp_q.pop_front();
                check("beat_data", out_if.out_data, b.d);
                check("beat_index", DW'(out_if.out_index), DW'(b.i));
                check("beat_last", DW'(out_if.out_last), DW'(b.l));
            end
        end
        prev_stall = out_if.out_valid && !out_if.out_ready;
        prev_b.d = out_if.out_data;
        prev_b.i = out_if.out_index;
        prev_b.l = out_if.out_last;
        if (done) begin
            done_cnt++;
            done_rel = cyc - t0;
        end
        if (rst) begin
            outstanding = 0;
            prev_stall  = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        hs_log.delete();
        valid_seen = 0;
    endtask

    task automatic load_cell(input int raw, output int n);
        beat_t b;
        logic [7:0] r8;
        r8 = 8'(raw);
        ram[0] = {$urandom(), $urandom(), 24'h0, r8};
        n = (raw > PN - 1) ? PN - 1 : raw;
        for (int k = 1; k <= n; k++) begin
            ram[k] = {$urandom(), $urandom(), $urandom()};
            b.d = ram[k];
            b.i = AW'(k);
            b.l = (k == n);
            exp_q.push_back(b);
        end
    endtask

    function automatic int rd_bad(input int n);
        if (rd_log.size() != n + 1) return 1000;
        for (int k = 0; k <= n; k++)
            if (rd_log[k] != k) return k + 1;
        return 0;
    endfunction

    task automatic outputs_zero(input string tag);
        check({tag, "_ctrl"},
              DW'({busy, done, particle_count, mem_rden, mem_address,
                   mem_wren, out_if.out_valid, out_if.out_index,
                   out_if.out_last}), DW'(0));
        check({tag, "_data"}, out_if.out_data, DW'(0));
    endtask

    // mode 0: ready high; mode 1: toggle then 6-cycle stall; mode 2: re-start mid-stream
    task automatic run(input int raw, input int mode, output int n);
        int base;
        int k;
        int rel;
        clear_logs();
        load_cell(raw, n);
        out_if.out_ready = 1'b1;
        base = done_cnt;
        pulse_start();
        k = 0;
        while (done_cnt == base && k < 600) begin
            rel = cyc - t0;
            if (mode == 1)
                out_if.out_ready = (rel < 20) ? rel[0] : (rel >= 26);
            if (mode == 2)
                start = (rel == 8);
            tick();
            k++;
        end
        start = 1'b0;
        out_if.out_ready = 1'b1;
        check("done_timeout", DW'(done_cnt != base), DW'(1));
        repeat (3) tick();
        check("done_once", DW'(done_cnt - base), DW'(1));
        check("busy_after", DW'(busy), DW'(0));
        check("count", DW'(particle_count), DW'(n));
        check("beats", DW'(hs_log.size()), DW'(n));
        check("sb_empty", DW'(exp_q.size()), DW'(0));
        check("rd_seq", DW'(rd_bad(n)), DW'(0));
        exp_q.delete();
    endtask

    initial begin
        int n;
        int bad;
        out_if.out_ready = 1'b1;
        for (int k = 0; k < 256; k++) ram[k] = '0;

        tick();
        tick();
        outputs_zero("reset");
        rst = 1'b0;
        tick();

        run(3, 0, n);
        check("t1_hs0", DW'(hs_log[0]), DW'(7));
        check("t1_hs1", DW'(hs_log[1]), DW'(8));
        check("t1_hs2", DW'(hs_log[2]), DW'(9));
        check("t1_done", DW'(done_rel), DW'(10));

        run(0, 0, n);
        check("t0_novalid", DW'(valid_seen), DW'(0));
        check("t0_done", DW'(done_rel), DW'(4));

        run(10, 1, n);
        run(255, 0, n);
        check("t255_lastrd", DW'(rd_log[rd_log.size() - 1]), DW'(219));
        run(1, 0, n);

        run(5, 2, n);
        bad = 0;
        for (int k = 0; k < hs_log.size(); k++)
            if (hs_log[k] != 7 + k) bad++;
        check("restart_seq", DW'(bad), DW'(0));

        clear_logs();
        load_cell(8, n);
        pulse_start();
        check("t8_busy", DW'(busy), DW'(1));
        check("t8_req", DW'({mem_rden, mem_address}), DW'({1'b1, 8'h00}));
        repeat (5) tick();
        rst = 1'b1;
        tick();
        outputs_zero("midrst");
        rst = 1'b0;
        exp_q.delete();
        check("midrst_nobeat", DW'(hs_log.size()), DW'(0));
        rd_log.delete();
        valid_seen = 0;
        repeat (3) tick();
        check("idle_noread", DW'(rd_log.size()), DW'(0));
        check("idle_novalid", DW'(valid_seen), DW'(0));
        run(8, 0, n);

        check("wren", DW'(wren_seen), DW'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
